// File: rtl/mbus_arb2_pkg.sv
// ---------------------------------------------------------------------------
// mbus_arb2_pkg -- constants shared by the CPU and its memory-bus arbiter.
//
// Holds the arbiter state codes (also exported on the 'owner' test port),
// the CPU scheduler phase codes, and the test-mux select codes that pick
// which internal observation signal is routed to a test pin.
// ---------------------------------------------------------------------------
package mbus_arb2_pkg;

  // Arbiter state codes; the encoding is visible on the 'owner' port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

  // CPU scheduler phases.  The CPU asks for the bus during any of them.
  localparam logic [1:0] PH_F = 2'd0;  // fetch
  localparam logic [1:0] PH_E = 2'd1;  // execute
  localparam logic [1:0] PH_M = 2'd2;  // memory
  localparam logic [1:0] PH_W = 2'd3;  // write-back

  // Test-mux selects for the arbiter observation ports.
  localparam logic [1:0] TSEL_NONE  = 2'd0;
  localparam logic [1:0] TSEL_OWNER = 2'd1;
  localparam logic [1:0] TSEL_BURST = 2'd2;

  // Grant decode for a given master index out of a state code.
  function automatic logic owns(input arb_state_e st, input logic idx);
    return idx ? (st == ST_OWN1) : (st == ST_OWN0);
  endfunction

endpackage

// File: rtl/mbus_arb2.sv
// ---------------------------------------------------------------------------
// mbus_arb2 -- two-master arbiter for a single shared memory bus.
//
// Master 0 is the CPU, master 1 is the DMA / debug loader.  One master owns
// the bus at a time; the owner transfers in every cycle it holds req.  A
// waiting master is served after at most MAX_BURST transfers of the owner,
// and ties from IDLE go to the master that did not own the bus last.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   mX_req/aout/dout/wen    master request, address, write data, write enable
//   mX_gnt                  registered grant (decoded from the state flop)
//   mX_din                  read data returned to the master (broadcast)
//   mbus_aout/dout/wen      shared bus address, write data, write strobe
//   mbus_din                shared bus read data
//   owner                   state code, for test muxes
//   burst_cnt               transfers made in the current burst
// ---------------------------------------------------------------------------
module mbus_arb2
  import mbus_arb2_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic [ADDR_SIZE-1:0] m0_aout,
  input  logic [WIDTH-1:0]     m0_dout,
  input  logic                 m0_wen,
  input  logic                 m1_req,
  input  logic [ADDR_SIZE-1:0] m1_aout,
  input  logic [WIDTH-1:0]     m1_dout,
  input  logic                 m1_wen,
  output logic                 m0_gnt,
  output logic                 m1_gnt,
  output logic [WIDTH-1:0]     m0_din,
  output logic [WIDTH-1:0]     m1_din,
  output logic [ADDR_SIZE-1:0] mbus_aout,
  output logic [WIDTH-1:0]     mbus_dout,
  output logic                 mbus_wen,
  input  logic [WIDTH-1:0]     mbus_din,
  output logic [1:0]           owner,
  output logic [7:0]           burst_cnt
);

  // Count value at which the current transfer ends a full burst.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  arb_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_owner_q, last_owner_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;

    case (state_q)
      ST_IDLE: begin
        // On a tie, master 0 wins only if master 1 owned the bus last.
        if (m0_req && (!m1_req || last_owner_q)) begin
          state_d = ST_OWN0;
        end else if (m1_req) begin
          state_d = ST_OWN1;
        end
      end

      ST_OWN0: begin
        if (!m0_req) begin
          state_d = m1_req ? ST_OWN1 : ST_IDLE;
        end else if (cnt_q == BURST_LAST) begin
          // Burst expired: rotate if the other master waits, else wrap.
          if (m1_req) begin
            state_d = ST_OWN1;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_OWN1: begin
        if (!m1_req) begin
          state_d = m0_req ? ST_OWN0 : ST_IDLE;
        end else if (cnt_q == BURST_LAST) begin
          if (m0_req) begin
            state_d = ST_OWN0;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        // 2'b11 is never entered; recover to IDLE if it ever appears.
        state_d = ST_IDLE;
      end
    endcase

    // Any state change starts a fresh burst and records a new owner.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == ST_OWN0) begin
        last_owner_d = 1'b0;
      end else if (state_d == ST_OWN1) begin
        last_owner_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign m0_gnt    = owns(state_q, 1'b0);
  assign m1_gnt    = owns(state_q, 1'b1);
  assign owner     = state_q;
  assign burst_cnt = cnt_q;

  assign mbus_aout = m0_gnt ? m0_aout : (m1_gnt ? m1_aout : '0);
  assign mbus_dout = m0_gnt ? m0_dout : (m1_gnt ? m1_dout : '0);
  assign mbus_wen  = (m0_gnt & m0_req & m0_wen) | (m1_gnt & m1_req & m1_wen);

  assign m0_din = mbus_din;
  assign m1_din = mbus_din;

endmodule

// File: tb/tb_mbus_arb2.sv
// ---------------------------------------------------------------------------
// tb_mbus_arb2 -- directed bench for mbus_arb2 with MAX_BURST = 8.
// Inputs change 1 ns after the rising edge; outputs are checked after that.
// ---------------------------------------------------------------------------
module tb_mbus_arb2;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned MAX_BURST = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 m0_req, m1_req;
  logic [ADDR_SIZE-1:0] m0_aout, m1_aout;
  logic [WIDTH-1:0]     m0_dout, m1_dout;
  logic                 m0_wen, m1_wen;
  logic                 m0_gnt, m1_gnt;
  logic [WIDTH-1:0]     m0_din, m1_din;
  logic [ADDR_SIZE-1:0] mbus_aout;
  logic [WIDTH-1:0]     mbus_dout;
  logic                 mbus_wen;
  logic [WIDTH-1:0]     mbus_din;
  logic [1:0]           owner;
  logic [7:0]           burst_cnt;

  int checks = 0;
  int errors = 0;

  mbus_arb2 #(
    .WIDTH    (WIDTH),
    .ADDR_SIZE(ADDR_SIZE),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_aout  (m0_aout),
    .m0_dout  (m0_dout),
    .m0_wen   (m0_wen),
    .m1_req   (m1_req),
    .m1_aout  (m1_aout),
    .m1_dout  (m1_dout),
    .m1_wen   (m1_wen),
    .m0_gnt   (m0_gnt),
    .m1_gnt   (m1_gnt),
    .m0_din   (m0_din),
    .m1_din   (m1_din),
    .mbus_aout(mbus_aout),
    .mbus_dout(mbus_dout),
    .mbus_wen (mbus_wen),
    .mbus_din (mbus_din),
    .owner    (owner),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs may be changed right after this returns.
  task automatic cyc();
    @(posedge clk);
    #1;
    mbus_din = $urandom;
  endtask

  task automatic chk_state(input string tag, input logic g0, input logic g1,
                           input logic [1:0] own, input logic [7:0] cnt);
    chk({tag, "_g0"},  64'(m0_gnt),    64'(g0));
    chk({tag, "_g1"},  64'(m1_gnt),    64'(g1));
    chk({tag, "_own"}, 64'(owner),     64'(own));
    chk({tag, "_cnt"}, 64'(burst_cnt), 64'(cnt));
  endtask

  // Read data must reach both masters unmodified in every cycle.
  always @(negedge clk) begin
    if (reset === 1'b0 || reset === 1'b1) begin
      chk("m0_din", 64'(m0_din), 64'(mbus_din));
      chk("m1_din", 64'(m1_din), 64'(mbus_din));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;

    // Reset held two cycles with both masters requesting.
    reset    = 1'b1;
    m0_req   = 1'b1;  m1_req  = 1'b1;
    m0_aout  = 32'h55; m1_aout = 32'h66;
    m0_dout  = 32'hA0A0_A0A0; m1_dout = 32'hB1B1_B1B1;
    m0_wen   = 1'b0;  m1_wen  = 1'b0;
    mbus_din = 32'h0;
    cyc();
    chk_state("rst1", 1'b0, 1'b0, 2'd0, 8'd0);
    chk("rst1_aout", 64'(mbus_aout), 64'h0);
    chk("rst1_dout", 64'(mbus_dout), 64'h0);
    chk("rst1_wen",  64'(mbus_wen),  64'h0);
    cyc();
    chk_state("rst2", 1'b0, 1'b0, 2'd0, 8'd0);
    reset = 1'b0;
    cyc();
    // Tie after reset goes to master 0.
    chk_state("rel", 1'b1, 1'b0, 2'd1, 8'd0);
    chk("rel_aout", 64'(mbus_aout), 64'h55);
    chk("rel_dout", 64'(mbus_dout), 64'hA0A0_A0A0);
    m0_req = 1'b0; m1_req = 1'b0;
    cyc();
    chk_state("idle0", 1'b0, 1'b0, 2'd0, 8'd0);
    chk("idle0_aout", 64'(mbus_aout), 64'h0);

    // Single master write from m1.
    m1_req = 1'b1; m1_aout = 32'h100; m1_dout = 32'hDEAD_BEEF; m1_wen = 1'b1;
    #1;
    chk("sw_pre_wen", 64'(mbus_wen), 64'h0);
    cyc();
    chk_state("sw_gnt", 1'b0, 1'b1, 2'd2, 8'd0);
    chk("sw_wen",  64'(mbus_wen),  64'h1);
    chk("sw_aout", 64'(mbus_aout), 64'h100);
    chk("sw_dout", 64'(mbus_dout), 64'hDEAD_BEEF);
    m1_req = 1'b0; m1_wen = 1'b0;
    #1;
    chk("sw_drop_wen", 64'(mbus_wen), 64'h0);
    cyc();
    chk_state("sw_idle", 1'b0, 1'b0, 2'd0, 8'd0);
    chk("sw_idle_wen", 64'(mbus_wen), 64'h0);

    // Both request continuously: 8 transfers each, alternating, no gap.
    m0_req = 1'b1; m1_req = 1'b1; m0_wen = 1'b1; m1_wen = 1'b0;
    m0_aout = 32'h40; m1_aout = 32'h80;
    for (int k = 0; k < 32; k++) begin
      cyc();
      if (((k / 8) % 2) == 0) begin
        chk_state($sformatf("rot%0d", k), 1'b1, 1'b0, 2'd1, 8'(k % 8));
        chk($sformatf("rot%0d_wen", k), 64'(mbus_wen), 64'h1);
      end else begin
        chk_state($sformatf("rot%0d", k), 1'b0, 1'b1, 2'd2, 8'(k % 8));
        chk($sformatf("rot%0d_wen", k), 64'(mbus_wen), 64'h0);
      end
    end

    // Gap-free handover: m0 releases as m1 raises.
    m0_req = 1'b0; m1_req = 1'b0; m0_wen = 1'b0;
    cyc();
    chk_state("ho_idle", 1'b0, 1'b0, 2'd0, 8'd0);
    m0_req = 1'b1;
    cyc();
    chk_state("ho_own0", 1'b1, 1'b0, 2'd1, 8'd0);
    cyc();
    chk_state("ho_own0b", 1'b1, 1'b0, 2'd1, 8'd1);
    m0_req = 1'b0; m1_req = 1'b1;
    cyc();
    chk_state("ho_own1", 1'b0, 1'b1, 2'd2, 8'd0);
    chk("ho_aout", 64'(mbus_aout), 64'h80);
    m1_req = 1'b0;
    cyc();
    chk_state("ho_idle2", 1'b0, 1'b0, 2'd0, 8'd0);

    // m0 alone for 20 cycles: counter wraps, grant never drops.
    m0_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk_state($sformatf("wrap%0d", k), 1'b1, 1'b0, 2'd1, 8'(k % 8));
    end

    // m1 raises at count 3: served after the transfers at 4..7.
    m1_req = 1'b1; m1_wen = 1'b1; m1_aout = 32'h200; m1_dout = 32'h1234_5678;
    waited = 0;
    for (int i = 1; i <= int'(MAX_BURST) + 1; i++) begin
      cyc();
      if (m1_gnt === 1'b1 && waited == 0) waited = i;
    end
    chk("starve_lat", 64'(waited), 64'd5);
    // Loop ran 4 more cycles in OWN1 after the grant.
    chk_state("mw_own1", 1'b0, 1'b1, 2'd2, 8'd4);
    chk("mw_wen",  64'(mbus_wen),  64'h1);
    chk("mw_aout", 64'(mbus_aout), 64'h200);

    // Reset in the middle of m1's write burst.
    reset = 1'b1;
    cyc();
    chk_state("mw_rst", 1'b0, 1'b0, 2'd0, 8'd0);
    chk("mw_rst_wen",  64'(mbus_wen),  64'h0);
    chk("mw_rst_aout", 64'(mbus_aout), 64'h0);
    reset = 1'b0;
    cyc();
    chk_state("mw_after", 1'b1, 1'b0, 2'd1, 8'd0);
    chk("mw_after_wen", 64'(mbus_wen), 64'h0);

    m0_req = 1'b0; m1_req = 1'b0; m1_wen = 1'b0;
    cyc();
    chk_state("end_idle", 1'b0, 1'b0, 2'd0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbus_arb2.md
MBUS_ARB2 -- requirements
Module: mbus_arb2

Interface
REQ-001 SHALL have parameters: WIDTH, 32, data width; ADDR_SIZE, 32, address width; MAX_BURST, 8, maximum consecutive transfers per grant while the other master waits (legal range 2..256).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- m0_req / m1_req  in  1  master requests a transfer this cycle.
- m0_aout / m1_aout  in  ADDR_SIZE  master address.
- m0_dout / m1_dout  in  WIDTH  master write data.
- m0_wen / m1_wen  in  1  master write enable.
- m0_gnt / m1_gnt  out  1  master owns the bus; registered.
- m0_din / m1_din  out  WIDTH  read data to master.
- mbus_aout  out  ADDR_SIZE  shared bus address.
- mbus_dout  out  WIDTH  shared bus write data.
- mbus_wen  out  1  shared bus write strobe.
- mbus_din  in  WIDTH  shared bus read data; combinational, valid in the cycle the address is driven.
- owner  out  2  state code, for test muxes.
- burst_cnt  out  8  current burst count, for test muxes.

Function
REQ-003 SHALL implement an FSM with states IDLE (2'b00), OWN0 (2'b01) and OWN1 (2'b10); owner SHALL equal the state code, and 2'b11 SHALL be unreachable.
REQ-004 mx_gnt SHALL be 1 exactly when the state is OWNx; at most one grant SHALL be high in any cycle.
REQ-005 A transfer SHALL occur in every cycle where mx_gnt=1 and mx_req=1.
REQ-006 In OWNx, mbus_aout and mbus_dout SHALL be mx_aout and mx_dout; in IDLE both SHALL be 0.
REQ-007 mbus_wen SHALL be mx_gnt & mx_req & mx_wen (combinational), and SHALL be 0 in IDLE.
REQ-008 mbus_din SHALL be broadcast unmodified to m0_din and m1_din.
REQ-009 IDLE transitions:
- no request: stay in IDLE.
- one request: go to that master's OWN state.
- both requests: go to OWN of the master that is not last_owner.
REQ-010 last_owner SHALL be a 1-bit register, updated to x on every entry into OWNx.
REQ-011 Request-to-grant latency from IDLE SHALL be 1 cycle; the first transfer occurs in the cycle after req is first sampled.
REQ-012 OWNx with mx_req=0: go to OWNy if my_req=1, else to IDLE; handover SHALL be gap-free, so OWNy starts the next cycle.
REQ-013 burst_cnt SHALL increment on each transfer and clear on every state change.
REQ-014 When a transfer occurs with burst_cnt=MAX_BURST-1:
- if my_req=1: go to OWNy (forced rotation).
- otherwise: stay in OWNx and wrap burst_cnt to 0.
REQ-015 A master whose request is held continuously SHALL be granted within MAX_BURST+1 cycles (no starvation).
REQ-016 Simultaneous release of x and request of y SHALL follow REQ-012; simultaneous burst expiry and release SHALL also go to OWNy when my_req=1.
REQ-017 Masters SHALL hold aout, dout and wen stable while req=1 and gnt=0; the arbiter SHALL not register master address or data.

Reset
REQ-018 When reset is sampled high, the following edge SHALL set: state IDLE, m0_gnt=0, m1_gnt=0, burst_cnt=0, last_owner=1 (master 0 wins the first tie).
REQ-019 Reset mid-burst SHALL abort the ownership; mbus_wen may be asserted in the reset cycle itself, but SHALL be 0 from the cycle after the reset edge.
REQ-020 mbus_aout, mbus_dout and mbus_wen SHALL be 0 while the state is IDLE after reset.

Structure
REQ-021 The state codes (IDLE/OWN0/OWN1) SHALL be constants in the shared CPU package, next to the phase and test-select constants.
REQ-022 The block SHALL be a single module with no sub-modules; the burst counter and FSM are inline, and the bus mux is a plain assignment.
REQ-023 The CPU SHALL connect as master 0, with m0_req = phf|phe|phm|phw of its scheduler; the second master (DMA or debug loader) SHALL connect as master 1.

Verification
REQ-024 Reset scenario: hold reset for 2 cycles with m0_req=m1_req=1 -> during reset gnt=00 and owner=0; 1 cycle after release m0_gnt=1.
REQ-025 Single-master scenario: m1 alone writes 0xDEADBEEF to address 0x100 -> m1_gnt=1 in cycle 1, mbus_wen=1 for exactly one cycle, mbus_aout=0x100; on req drop, owner returns to 0 the next cycle.
REQ-026 Forced rotation scenario: both masters request continuously, MAX_BURST=8 -> grants alternate 8 transfers m0 then 8 transfers m1, with no idle cycle between them.
REQ-027 Gap-free handover scenario: m0 owns, drops req in the same cycle m1 raises req -> m1_gnt=1 in the next cycle with burst_cnt=0.
REQ-028 Solo wrap scenario: m0 requests alone for 20 cycles -> m0_gnt stays 1 and burst_cnt follows 0..7,0..7,0..3.
REQ-029 Mid-write reset scenario: assert reset while m1 is writing -> mbus_wen=0 and both grants 0 from the cycle after the reset edge; read data is checked equal on m0_din and m1_din in every cycle.
